// File: rtl/dma_pkg.sv
// Shared definitions for the memory-copy DMA.
//   dma_state_e : copy engine FSM states
//   WORD_BYTES  : address stride between consecutive 32-bit words
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      FINISH  = 3'd5
   } dma_state_e;

   localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/ibex_data_bus.sv
// Ibex-style data bus bundle.
//   master : drives req/addr/we/be/wdata, receives gnt/rvalid/rdata/err
//   slave  : the responder side
// Handshake: a request is accepted on the rising edge where req=1 and gnt=1;
// addr/we/be/wdata hold while req=1 and gnt=0. The response (rvalid, with
// rdata for reads and err for both) arrives in a later cycle.
interface ibex_data_bus;

   logic        req;
   logic        gnt;
   logic        rvalid;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine on an Ibex-style data bus.
// Each word is read from the source, buffered, then written to the
// destination; only one bus transaction is ever outstanding.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : single-cycle copy request (ignored while busy)
//   src_addr        : source byte address (low two bits dropped)
//   dst_addr        : destination byte address (low two bits dropped)
//   len_words       : number of 32-bit words; 0 completes immediately
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse when a copy ends (normally or on error)
//   error           : sticky bus-error flag, cleared by the next accepted start
//   error_addr      : byte address of the access that returned err
//   data_bus        : bus initiator
module mem_copy_dma
   import dma_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [LEN_WIDTH-1:0] len_words,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [31:0]          error_addr,
   ibex_data_bus.master         data_bus
);

   dma_state_e           state_q, state_d;
   logic [31:0]          src_q, src_d;
   logic [31:0]          dst_q, dst_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          buf_q, buf_d;
   logic                 error_q, error_d;
   logic [31:0]          error_addr_q, error_addr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         cnt_q        <= '0;
         buf_q        <= '0;
         error_q      <= 1'b0;
         error_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         error_q      <= error_d;
         error_addr_q <= error_addr_d;
      end
   end

   // Bus outputs are decoded from registered state only, so they cannot
   // change during a gnt stall and drop straight to 0 when reset asserts.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      error_d      = error_q;
      error_addr_d = error_addr_q;

      data_bus.req   = 1'b0;
      data_bus.we    = 1'b0;
      data_bus.be    = 4'h0;
      data_bus.addr  = '0;
      data_bus.wdata = buf_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               error_d = 1'b0;
               if (len_words != '0) begin
                  src_d   = {src_addr[31:2], 2'b00};
                  dst_d   = {dst_addr[31:2], 2'b00};
                  cnt_d   = len_words;
                  state_d = RD_REQ;
               end else begin
                  state_d = FINISH;
               end
            end
         end

         RD_REQ: begin
            data_bus.req  = 1'b1;
            data_bus.be   = 4'hF;
            data_bus.addr = src_q;
            if (data_bus.gnt) state_d = RD_WAIT;
         end

         RD_WAIT: begin
            if (data_bus.rvalid) begin
               if (data_bus.err) begin
                  error_d      = 1'b1;
                  error_addr_d = src_q;
                  state_d      = FINISH;
               end else begin
                  buf_d   = data_bus.rdata;
                  state_d = WR_REQ;
               end
            end
         end

         WR_REQ: begin
            data_bus.req  = 1'b1;
            data_bus.we   = 1'b1;
            data_bus.be   = 4'hF;
            data_bus.addr = dst_q;
            if (data_bus.gnt) state_d = WR_WAIT;
         end

         WR_WAIT: begin
            if (data_bus.rvalid) begin
               if (data_bus.err) begin
                  error_d      = 1'b1;
                  error_addr_d = dst_q;
                  state_d      = FINISH;
               end else begin
                  // Pointers wrap naturally at 2^32.
                  src_d   = src_q + WORD_BYTES;
                  dst_d   = dst_q + WORD_BYTES;
                  cnt_d   = cnt_q - LEN_WIDTH'(1);
                  state_d = (cnt_q == LEN_WIDTH'(1)) ? FINISH : RD_REQ;
               end
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FINISH);
   assign error      = error_q;
   assign error_addr = error_addr_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: a memory responder with configurable
// gnt stall and error injection, a scoreboard of expected bus transactions,
// a table of copy scenarios and hand sequences for mid-copy start and reset.
module tb_mem_copy_dma;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len_words;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] error_addr;

   ibex_data_bus bus ();

   mem_copy_dma #(.LEN_WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len_words  (len_words),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .error_addr (error_addr),
      .data_bus   (bus.master)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_val(a);
   endfunction

   // ---------------- responder ----------------
   int          stall_cfg = 0;
   int          stall_cnt;
   bit          err_en = 1'b0;
   logic [31:0] err_at = '0;

   assign bus.gnt = bus.req && (stall_cnt >= stall_cfg);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= 0;
         bus.rvalid <= 1'b0;
         bus.err    <= 1'b0;
         bus.rdata  <= '0;
      end else begin
         bus.rvalid <= 1'b0;
         bus.err    <= 1'b0;
         if (bus.req && bus.gnt) begin
            stall_cnt  <= 0;
            bus.rvalid <= 1'b1;
            bus.err    <= err_en && (bus.addr == err_at);
            if (!bus.we) bus.rdata <= mem_rd(bus.addr);
         end else if (bus.req) begin
            stall_cnt <= stall_cnt + 1;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [32:0]  exp_q[$];
   int           req_cycles;
   int           done_cycles;
   int           write_cnt;
   bit           prev_stall;
   logic [68:0]  stall_snap;
   logic [32:0]  item;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.req) req_cycles++;
         if (done) done_cycles++;
         if (prev_stall && bus.req)
            check("stall_stable", {bus.addr, bus.we, bus.be, bus.wdata}, stall_snap);
         prev_stall = bus.req && !bus.gnt;
         stall_snap = {bus.addr, bus.we, bus.be, bus.wdata};
         if (bus.req && bus.gnt) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_extra: got %0h expected no transaction", {bus.we, bus.addr});
            end else begin
               item = exp_q.pop_front();
               check("bus_txn", {bus.we, bus.addr}, item);
            end
            check("bus_be", bus.be, 4'hF);
            if (bus.we && !(err_en && bus.addr == err_at)) begin
               mem[bus.addr] = bus.wdata;
               write_cnt++;
            end
         end
      end
   end

   // ---------------- scenario table ----------------
   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      int          stall;
      bit          err_en;
      logic [31:0] err_at;
      int          exp_cyc;
      bit          exp_err;
      logic [31:0] exp_eaddr;
      int          exp_writes;
   } vec_t;

   vec_t vecs [6];

   // Drives one copy, optionally firing a second start at cycle extra_at
   // (counted from the cycle start is sampled), and checks the outcome.
   task automatic run_copy(input vec_t v, input int extra_at);
      logic [31:0] s;
      logic [31:0] d;
      int          cyc;
      stall_cfg   = v.stall;
      err_en      = v.err_en;
      err_at      = v.err_at;
      req_cycles  = 0;
      done_cycles = 0;
      write_cnt   = 0;
      s = {v.src[31:2], 2'b00};
      d = {v.dst[31:2], 2'b00};
      for (int i = 0; i < int'(v.len); i++) begin
         exp_q.push_back({1'b0, s});
         if (v.err_en && s == v.err_at) break;
         exp_q.push_back({1'b1, d});
         if (v.err_en && d == v.err_at) break;
         s = s + 32'd4;
         d = d + 32'd4;
      end
      @(negedge clk);
      start     = 1'b1;
      src_addr  = v.src;
      dst_addr  = v.dst;
      len_words = v.len;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 200) begin
         if (cyc == extra_at) begin
            start     = 1'b1;
            src_addr  = 32'h0000_2000;
            dst_addr  = 32'h0000_3000;
            len_words = 16'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done at %0d", cyc, v.exp_cyc);
      end
      check("done_latency", cyc, v.exp_cyc);
      check("error_flag", error, v.exp_err);
      if (v.exp_err) check("error_addr", error_addr, v.exp_eaddr);
      @(negedge clk);
      check("done_width", done, 1'b0);
      check("busy_after", busy, 1'b0);
      repeat (2) @(negedge clk);
      check("done_pulses", done_cycles, 1);
      check("write_count", write_cnt, v.exp_writes);
      check("txn_left", exp_q.size(), 0);
      check("error_hold", error, v.exp_err);
      if (v.exp_err) check("error_addr_hold", error_addr, v.exp_eaddr);
      if (v.len == 16'd0) check("req_cycles_len0", req_cycles, 0);
      s = {v.src[31:2], 2'b00};
      d = {v.dst[31:2], 2'b00};
      for (int i = 0; i < v.exp_writes; i++)
         check("mem_copy", mem_rd(d + 32'(4 * i)), init_val(s + 32'(4 * i)));
      if (v.exp_writes < int'(v.len))
         check("mem_untouched", mem_rd(d + 32'(4 * v.exp_writes)), init_val(d + 32'(4 * v.exp_writes)));
      exp_q.delete();
   endtask

   // ---------------- main sequence ----------------
   vec_t hv;

   initial begin
      //         src           dst           len  stall err  err_at        cyc err  eaddr         writes
      vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd1, 0, 1'b0, 32'h0,         5, 1'b0, 32'h0,         1};
      vecs[1] = '{32'h0000_0400, 32'h0000_0500, 16'd4, 3, 1'b0, 32'h0,        41, 1'b0, 32'h0,         4};
      vecs[2] = '{32'h0000_0100, 32'h0000_0300, 16'd3, 0, 1'b1, 32'h0000_0104, 7, 1'b1, 32'h0000_0104, 1};
      vecs[3] = '{32'h0000_0600, 32'h0000_0700, 16'd0, 0, 1'b0, 32'h0,         1, 1'b0, 32'h0,         0};
      vecs[4] = '{32'h0000_0803, 32'h0000_0902, 16'd2, 1, 1'b0, 32'h0,        13, 1'b0, 32'h0,         2};
      vecs[5] = '{32'h0000_0B00, 32'h0000_0A00, 16'd2, 0, 1'b1, 32'h0000_0A04, 9, 1'b1, 32'h0000_0A04, 1};

      rst_n     = 1'b0;
      start     = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      len_words = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_error_addr", error_addr, 32'h0);
      check("rst_req", bus.req, 1'b0);
      check("rst_we", bus.we, 1'b0);
      check("rst_be", bus.be, 4'h0);
      check("rst_addr", bus.addr, 32'h0);
      check("rst_wdata", bus.wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 6; k++) run_copy(vecs[k], 0);

      // Extra start in WR_REQ must not disturb the copy; second read wraps to 0.
      hv = '{32'hFFFF_FFFC, 32'h0000_1000, 16'd2, 0, 1'b0, 32'h0, 9, 1'b0, 32'h0, 2};
      run_copy(hv, 3);

      // Reset while stalled in RD_REQ.
      stall_cfg = 50;
      err_en    = 1'b0;
      @(negedge clk);
      start     = 1'b1;
      src_addr  = 32'h0000_0C00;
      dst_addr  = 32'h0000_0D00;
      len_words = 16'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("stalled_req", bus.req, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", bus.req, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_addr", bus.addr, 32'h0);
      check("mid_rst_be", bus.be, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      hv = '{32'h0000_0C00, 32'h0000_0D00, 16'd2, 0, 1'b0, 32'h0, 9, 1'b0, 32'h0, 2};
      run_copy(hv, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 The block SHALL have parameter LEN_WIDTH, default 16, giving the width of the word-count input.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  single-cycle copy request.
REQ-005 The block SHALL have port src_addr  input  32  source byte address.
REQ-006 The block SHALL have port dst_addr  input  32  destination byte address.
REQ-007 The block SHALL have port len_words  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-008 The block SHALL have port busy  output  1  high while a copy is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse at the end of a copy.
REQ-010 The block SHALL have port error  output  1  sticky bus-error flag.
REQ-011 The block SHALL have port error_addr  output  32  byte address of the access that returned err.
REQ-012 The block SHALL have port data_bus  ibex_data_bus.master  --  initiator side of the data bus (req, gnt, rvalid, addr, we, be, wdata, rdata, err).

Function
REQ-013 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
REQ-014 In IDLE, start=1 with len_words!=0 SHALL latch src/dst (bits [1:0] forced to 0) and len_words, clear error, and enter RD_REQ.
REQ-015 In IDLE, start=1 with len_words=0 SHALL clear error, enter FINISH and issue no bus request.
REQ-016 start while busy=1 SHALL be ignored, with no effect on latched values.
REQ-017 In RD_REQ the block SHALL drive req=1, we=0, be=4'hF, addr=current source, and SHALL go to RD_WAIT on the cycle gnt=1.
REQ-018 In WR_REQ the block SHALL drive req=1, we=1, be=4'hF, addr=current destination, wdata=buffered word, and SHALL go to WR_WAIT on gnt=1.
REQ-019 addr, we, be and wdata SHALL stay stable while req=1 and gnt=0; gnt in the first req cycle SHALL be accepted.
REQ-020 req SHALL be 0 in IDLE, RD_WAIT, WR_WAIT and FINISH; at most one transaction SHALL be outstanding.
REQ-021 In RD_WAIT, rvalid=1 with err=0 SHALL capture rdata into a 32-bit buffer and enter WR_REQ.
REQ-022 In WR_WAIT, rvalid=1 with err=0 SHALL advance source and destination by 4 (modulo 2^32) and decrement the count; count reaching 0 SHALL enter FINISH, otherwise RD_REQ.
REQ-023 rvalid=1 with err=1 in either WAIT state SHALL set error=1, load error_addr with that access's address, and enter FINISH, abandoning remaining words.
REQ-024 rvalid outside the WAIT states SHALL be ignored.
REQ-025 FINISH SHALL assert done=1 for exactly one cycle, then enter IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 error and error_addr SHALL hold their values until the next accepted start.
REQ-028 With a zero-wait responder (gnt=req, rvalid one cycle after gnt), an N-word copy SHALL take 4N cycles of bus activity, with done high 4N+1 cycles after the start edge.

Reset
REQ-029 While rst_n=0 the FSM SHALL be IDLE, and busy, done, error, req and we SHALL be 0.
REQ-030 While rst_n=0, error_addr, addr, wdata and the buffer SHALL be 0 and be SHALL be 4'h0.
REQ-031 Reset asserted mid-copy SHALL drop req immediately, without completing the pending transaction.

Structure
REQ-032 Package dma_pkg SHALL hold the FSM state enum and constant WORD_BYTES=4.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 The bench SHALL cover: zero-wait responder, src=0x100, dst=0x200, len=1, mem[0x100]=0xDEADBEEF -> mem[0x200]=0xDEADBEEF, done 5 cycles after start, error=0.
REQ-035 The bench SHALL cover: len=4, responder withholding gnt 3 cycles per request -> addr, we and wdata stable during the stall, 4 words copied, one done pulse.
REQ-036 The bench SHALL cover: len=3, err=1 on the second read (src+4=0x104) -> error=1, error_addr=0x104, one write done, done pulses, busy falls.
REQ-037 The bench SHALL cover: len=0 -> done pulse the cycle after start, req never asserted.
REQ-038 The bench SHALL cover: start during a copy and src=0xFFFFFFFC with len=2 -> the extra start is ignored, and the second read targets 0x00000000 (wrap).
REQ-039 The bench SHALL cover: rst_n low while in RD_REQ with gnt=0 -> req=0 and busy=0 immediately; a new start then copies correctly.
